// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : M->W pipeline register and writeback decode of the MIPS core;
//                extends sub-word loads and counts retired instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_wb_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IR_M,
    input  logic [31:0]      PC4_M,
    input  logic [31:0]      ALUOut_M,
    input  logic [31:0]      DMOut_M,
    input  logic             BubbleM,
    output logic [31:0]      IR_W,
    output logic [31:0]      PC4,
    output logic [4:0]       R3,
    output logic [31:0]      RFIn,
    output logic             RegWr,
    output logic [CNT_W-1:0] Retired
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_LB    = 6'b100000;
    localparam logic [5:0] c_OP_LH    = 6'b100001;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_LBU   = 6'b100100;
    localparam logic [5:0] c_OP_LHU   = 6'b100101;
    localparam logic [5:0] c_FN_JR    = 6'b001000;
    localparam logic [5:0] c_FN_JALR  = 6'b001001;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      ir_q, ir_d;
    logic [31:0]      pc4_q, pc4_d;
    logic [31:0]      alu_q, alu_d;
    logic [31:0]      dm_q, dm_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    always_comb begin
        ir_d  = BubbleM ? 32'd0 : IR_M;
        pc4_d = PC4_M;
        alu_d = ALUOut_M;
        dm_d  = DMOut_M;
        ret_d = (ir_q != 32'd0) ? (ret_q + c_CNT_ONE) : ret_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q  <= 32'd0;
            pc4_q <= PC_RESET + 32'd4;
            alu_q <= 32'd0;
            dm_q  <= 32'd0;
            ret_q <= '0;
        end else begin
            ir_q  <= ir_d;
            pc4_q <= pc4_d;
            alu_q <= alu_d;
            dm_q  <= dm_d;
            ret_q <= ret_d;
        end
    end

    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rt, w_rd;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_dst;
    logic [31:0] w_data;
    logic        w_wr;

    assign w_op   = ir_q[31:26];
    assign w_fn   = ir_q[5:0];
    assign w_rt   = ir_q[20:16];
    assign w_rd   = ir_q[15:11];
    // Halfword select ignores address bit 0 on purpose (no misalignment trap)
    assign w_half = alu_q[1] ? dm_q[31:16] : dm_q[15:0];

    always_comb begin
        w_byte = dm_q[7:0];
        case (alu_q[1:0])
            2'd1:    w_byte = dm_q[15:8];
            2'd2:    w_byte = dm_q[23:16];
            2'd3:    w_byte = dm_q[31:24];
            default: w_byte = dm_q[7:0];
        endcase
    end

    always_comb begin
        w_dst  = 5'd0;
        w_data = 32'd0;
        w_wr   = 1'b0;
        case (w_op)
            c_OP_RTYPE: begin
                w_dst  = w_rd;
                w_data = (w_fn == c_FN_JALR) ? (pc4_q + 32'd4) : alu_q;
                w_wr   = (w_fn != c_FN_JR);
            end
            c_OP_JAL: begin
                w_dst  = 5'd31;
                w_data = pc4_q + 32'd4;
                w_wr   = 1'b1;
            end
            c_OP_LW:  begin w_dst = w_rt; w_data = dm_q;                      w_wr = 1'b1; end
            c_OP_LB:  begin w_dst = w_rt; w_data = {{24{w_byte[7]}}, w_byte}; w_wr = 1'b1; end
            c_OP_LBU: begin w_dst = w_rt; w_data = {24'd0, w_byte};           w_wr = 1'b1; end
            c_OP_LH:  begin w_dst = w_rt; w_data = {{16{w_half[15]}}, w_half}; w_wr = 1'b1; end
            c_OP_LHU: begin w_dst = w_rt; w_data = {16'd0, w_half};           w_wr = 1'b1; end
            default: begin
                // 001xxx covers addi/addiu/slti/sltiu/andi/ori/xori/lui
                if (w_op[5:3] == 3'b001) begin
                    w_dst  = w_rt;
                    w_data = alu_q;
                    w_wr   = 1'b1;
                end
            end
        endcase
        // A bubble must look completely idle, not like sll $0
        if (ir_q == 32'd0) begin
            w_dst  = 5'd0;
            w_data = 32'd0;
            w_wr   = 1'b0;
        end
    end

    assign IR_W    = ir_q;
    assign PC4     = pc4_q;
    assign R3      = w_dst;
    assign RFIn    = w_data;
    // Reset discards the instruction currently in W, so no write leaves this cycle
    assign RegWr   = w_wr && (w_dst != 5'd0) && !reset;
    assign Retired = ret_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Directed vector bench for mem_wb_stage writeback decode.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_wb_stage;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] dm;
        logic        bub;
        logic [4:0]  r3;
        logic [31:0] rfin;
        logic        wr;
        logic        chk_data;
    } vec_t;

    localparam int c_NVEC = 19;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_M, PC4_M, ALUOut_M, DMOut_M;
    logic        BubbleM;
    logic [31:0] IR_W, PC4;
    logic [4:0]  R3;
    logic [31:0] RFIn;
    logic        RegWr;
    logic [31:0] Retired;
    logic [31:0] s_IR_W, s_PC4;
    logic [4:0]  s_R3;
    logic [31:0] s_RFIn;
    logic        s_RegWr;
    logic [3:0]  s_Retired;

    int n_vec = 0;
    int n_err = 0;
    vec_t vt[c_NVEC];
    logic [31:0] exp_ret;
    logic [31:0] model_irw;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .reset(reset), .IR_M(IR_M), .PC4_M(PC4_M), .ALUOut_M(ALUOut_M),
        .DMOut_M(DMOut_M), .BubbleM(BubbleM), .IR_W(IR_W), .PC4(PC4), .R3(R3),
        .RFIn(RFIn), .RegWr(RegWr), .Retired(Retired)
    );

    mem_wb_stage #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .IR_M(IR_M), .PC4_M(PC4_M), .ALUOut_M(ALUOut_M),
        .DMOut_M(DMOut_M), .BubbleM(BubbleM), .IR_W(s_IR_W), .PC4(s_PC4), .R3(s_R3),
        .RFIn(s_RFIn), .RegWr(s_RegWr), .Retired(s_Retired)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] ir, input logic [31:0] pc4,
                                input logic [31:0] alu, input logic [31:0] dm,
                                input logic bub, input logic [4:0] r3,
                                input logic [31:0] rfin, input logic wr,
                                input logic chk_data);
        vec_t v;
        v.ir = ir; v.pc4 = pc4; v.alu = alu; v.dm = dm; v.bub = bub;
        v.r3 = r3; v.rfin = rfin; v.wr = wr; v.chk_data = chk_data;
        return v;
    endfunction

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc4,
                         input logic [31:0] alu, input logic [31:0] dm, input logic bub);
        IR_M = ir; PC4_M = pc4; ALUOut_M = alu; DMOut_M = dm; BubbleM = bub;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = mk(32'h8C08_0000, 32'h0000_3004, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 5'd8,  32'hDEAD_BEEF, 1'b1, 1'b1); // lw
        vt[1]  = mk(32'h8009_0003, 32'h0000_3008, 32'h0000_0003, 32'h80FF_1234, 1'b0, 5'd9,  32'hFFFF_FF80, 1'b1, 1'b1); // lb b3
        vt[2]  = mk(32'h9009_0003, 32'h0000_300C, 32'h0000_0003, 32'h80FF_1234, 1'b0, 5'd9,  32'h0000_0080, 1'b1, 1'b1); // lbu b3
        vt[3]  = mk(32'h8009_0000, 32'h0000_3010, 32'h0000_0000, 32'h80FF_1234, 1'b0, 5'd9,  32'h0000_0034, 1'b1, 1'b1); // lb b0
        vt[4]  = mk(32'h9009_0001, 32'h0000_3014, 32'h0000_0001, 32'h80FF_1234, 1'b0, 5'd9,  32'h0000_0012, 1'b1, 1'b1); // lbu b1
        vt[5]  = mk(32'h840A_0002, 32'h0000_3018, 32'h0000_0002, 32'h8001_7FFF, 1'b0, 5'd10, 32'hFFFF_8001, 1'b1, 1'b1); // lh h1
        vt[6]  = mk(32'h940A_0002, 32'h0000_301C, 32'h0000_0002, 32'h8001_7FFF, 1'b0, 5'd10, 32'h0000_8001, 1'b1, 1'b1); // lhu h1
        vt[7]  = mk(32'h840A_0003, 32'h0000_3020, 32'h0000_0003, 32'h8001_7FFF, 1'b0, 5'd10, 32'hFFFF_8001, 1'b1, 1'b1); // lh odd
        vt[8]  = mk(32'h940A_0000, 32'h0000_3024, 32'h0000_0000, 32'h8001_7FFF, 1'b0, 5'd10, 32'h0000_7FFF, 1'b1, 1'b1); // lhu h0
        vt[9]  = mk(32'h0C00_0C02, 32'h0000_3008, 32'h0000_0000, 32'h0000_0000, 1'b0, 5'd31, 32'h0000_300C, 1'b1, 1'b1); // jal
        vt[10] = mk(32'hAC08_0000, 32'h0000_3030, 32'h0000_0040, 32'h1111_2222, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b1); // sw
        vt[11] = mk(32'h0022_1821, 32'h0000_3034, 32'h0000_0055, 32'h0000_0000, 1'b0, 5'd3,  32'h0000_0055, 1'b1, 1'b1); // addu
        vt[12] = mk(32'h0080_F809, 32'h0000_4000, 32'h0000_1234, 32'h0000_0000, 1'b0, 5'd31, 32'h0000_4004, 1'b1, 1'b1); // jalr
        vt[13] = mk(32'h0080_0008, 32'h0000_4004, 32'h0000_0000, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b1); // jr
        vt[14] = mk(32'h3405_00FF, 32'h0000_4008, 32'h0000_00FF, 32'h0000_0000, 1'b0, 5'd5,  32'h0000_00FF, 1'b1, 1'b1); // ori
        vt[15] = mk(32'h3C06_1234, 32'h0000_400C, 32'h1234_0000, 32'h0000_0000, 1'b0, 5'd6,  32'h1234_0000, 1'b1, 1'b1); // lui
        vt[16] = mk(32'h1022_0004, 32'h0000_4010, 32'h0000_0001, 32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b1); // beq
        vt[17] = mk(32'h8C00_0000, 32'h0000_4014, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b0); // lw $0
        vt[18] = mk(32'h8C08_0000, 32'h0000_4018, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 5'd0,  32'h0000_0000, 1'b0, 1'b1); // bubble

        reset = 1'b1;
        drive(32'h8C08_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_IR_W",    IR_W,            32'h0);
        check("reset_PC4",     PC4,             32'h0000_3004);
        check("reset_R3",      {27'd0, R3},     32'h0);
        check("reset_RFIn",    RFIn,            32'h0);
        check("reset_RegWr",   {31'd0, RegWr},  32'h0);
        check("reset_Retired", Retired,         32'h0);
        reset     = 1'b0;
        exp_ret   = 32'd0;
        model_irw = 32'd0;

        for (int i = 0; i < c_NVEC; i++) begin
            drive(vt[i].ir, vt[i].pc4, vt[i].alu, vt[i].dm, vt[i].bub);
            @(posedge clk);
            if (model_irw != 32'd0) exp_ret++;
            model_irw = vt[i].bub ? 32'd0 : vt[i].ir;
            #1;
            check($sformatf("v%0d_IR_W", i),  IR_W,           model_irw);
            check($sformatf("v%0d_PC4", i),   PC4,            vt[i].pc4);
            check($sformatf("v%0d_R3", i),    {27'd0, R3},    {27'd0, vt[i].r3});
            check($sformatf("v%0d_RegWr", i), {31'd0, RegWr}, {31'd0, vt[i].wr});
            if (vt[i].chk_data)
                check($sformatf("v%0d_RFIn", i), RFIn, vt[i].rfin);
            check($sformatf("v%0d_Retired", i), Retired, exp_ret);
        end

        // jal after the bubble: the bubble edge must not count
        drive(32'h0C00_0C02, 32'h0000_5000, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("jal_w_RegWr",   {31'd0, RegWr}, 32'h1);
        check("jal_w_RFIn",    RFIn,           32'h0000_5004);
        check("post_bubble_Retired", Retired,  exp_ret);
        reset = 1'b1;
        #1;
        check("rst_mid_RegWr", {31'd0, RegWr}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_mid_Retired", Retired,      32'h0);
        check("rst_mid_IR_W",    IR_W,         32'h0);
        reset = 1'b0;

        // 16 addiu $0 writes on the 4-bit counter instance
        for (int k = 0; k < 16; k++) begin
            drive(32'h2400_0001, 32'h0000_6000, 32'h0000_0001, 32'h0, 1'b0);
            @(posedge clk);
            #1;
            check($sformatf("addiu0_%0d_RegWr", k), {31'd0, RegWr}, 32'h0);
            check($sformatf("addiu0_%0d_Retired", k), {28'd0, s_Retired}, k[31:0]);
        end
        drive(32'h0, 32'h0000_6004, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("wrap_small_Retired", {28'd0, s_Retired}, 32'h0);
        check("wrap_big_Retired",   Retired,            32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
